rf_write_arbiter: RTL and testbench

Write-port arbiter for the 64-entry, 32-bit integer register file (3 write ports, physical register 0 hardwired to zero). It collects writeback results from NUM_REQ producers (ALUs, load unit, multiplier, divider) over valid/ready handshakes and grants up to NUM_WRITE of them per cycle using rotating round-robin priority. Granted writes are registered and driven onto the register file write ports one cycle later.

---
 rtl/rf_write_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: grants up to NUM_WRITE of NUM_REQ writeback
// requesters per cycle in rotating round-robin order and registers the winners.
module rf_write_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int NUM_WRITE = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        IN_valid,
  input  logic [NUM_REQ*6-1:0]      IN_addr,
  input  logic [NUM_REQ*32-1:0]     IN_data,
  output logic [NUM_REQ-1:0]        OUT_ready,
  output logic [NUM_WRITE-1:0]      OUT_writeEnable,
  output logic [NUM_WRITE*6-1:0]    OUT_writeAddress,
  output logic [NUM_WRITE*32-1:0]   OUT_writeData
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int UW = (NUM_WRITE > 1) ? $clog2(NUM_WRITE) : 1;

  logic [PW-1:0]      ptr_reg;
  logic [PW-1:0]      ptr_next;
  logic [5:0]         req_addr [NUM_REQ];
  logic [31:0]        req_data [NUM_REQ];
  logic [NUM_REQ-1:0] ready_next;

  logic [NUM_WRITE-1:0] grant_en_next;
  logic [5:0]           grant_addr_next [NUM_WRITE];
  logic [31:0]          grant_data_next [NUM_WRITE];

  logic [NUM_WRITE-1:0] bank_en_reg;
  logic [5:0]           bank_addr_reg [NUM_WRITE];
  logic [31:0]          bank_data_reg [NUM_WRITE];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_addr[gi] = IN_addr[gi*6 +: 6];
      assign req_data[gi] = IN_data[gi*32 +: 32];
    end
  endgenerate

  // Scan from ptr with wrap; ports fill in ascending order, and an address
  // already claimed this cycle blocks later requesters so no two ports collide.
  always_comb begin
    int            idx;
    int            used;
    int            last;
    int            nxt;
    logic          conflict;
    logic [PW-1:0] idx_v;

    ready_next    = '0;
    grant_en_next = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      grant_addr_next[p] = 6'd0;
      grant_data_next[p] = 32'd0;
    end
    used     = 0;
    last     = int'(ptr_reg);
    nxt      = 0;
    conflict = 1'b0;
    idx_v    = '0;

    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = PW'(idx);
      if (IN_valid[idx_v]) begin
        if (req_addr[idx_v] == 6'd0) begin
          ready_next[idx_v] = 1'b1;
        end else begin
          conflict = 1'b0;
          for (int p = 0; p < NUM_WRITE; p++) begin
            if (p < used && grant_addr_next[p] == req_addr[idx_v]) conflict = 1'b1;
          end
          if (!conflict && used < NUM_WRITE) begin
            ready_next[idx_v]             = 1'b1;
            grant_en_next[UW'(used)]      = 1'b1;
            grant_addr_next[UW'(used)]    = req_addr[idx_v];
            grant_data_next[UW'(used)]    = req_data[idx_v];
            used = used + 1;
            last = idx;
          end
        end
      end
    end

    if (used > 0) begin
      nxt = last + 1;
      if (nxt >= NUM_REQ) nxt = 0;
      ptr_next = PW'(nxt);
    end else begin
      ptr_next = ptr_reg;
    end
  end

  assign OUT_ready = rst ? '0 : ready_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg     <= '0;
      bank_en_reg <= '0;
      for (int p = 0; p < NUM_WRITE; p++) begin
        bank_addr_reg[p] <= 6'd0;
        bank_data_reg[p] <= 32'd0;
      end
    end else begin
      ptr_reg     <= ptr_next;
      bank_en_reg <= grant_en_next;
      for (int p = 0; p < NUM_WRITE; p++) begin
        bank_addr_reg[p] <= grant_addr_next[p];
        bank_data_reg[p] <= grant_data_next[p];
      end
    end
  end

  assign OUT_writeEnable = bank_en_reg;

  generate
    for (gi = 0; gi < NUM_WRITE; gi++) begin : g_port
      assign OUT_writeAddress[gi*6 +: 6]  = bank_addr_reg[gi];
      assign OUT_writeData[gi*32 +: 32]   = bank_data_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed table-driven bench for rf_write_arbiter (NUM_REQ=5, NUM_WRITE=3),
// plus hand-written reset sequences at start and mid-operation.
module tb_rf_write_arbiter;

  logic         clk;
  logic         rst;
  logic [4:0]   in_valid;
  logic [29:0]  in_addr;
  logic [159:0] in_data;
  logic [4:0]   out_ready;
  logic [2:0]   out_we;
  logic [17:0]  out_wa;
  logic [95:0]  out_wd;

  int n_cmp = 0;
  int n_err = 0;

  rf_write_arbiter #(.NUM_REQ(5), .NUM_WRITE(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .IN_valid         (in_valid),
    .IN_addr          (in_addr),
    .IN_data          (in_data),
    .OUT_ready        (out_ready),
    .OUT_writeEnable  (out_we),
    .OUT_writeAddress (out_wa),
    .OUT_writeData    (out_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  valid;
    logic [29:0] addr;   // requester i at [i*6+:6]
    logic [4:0]  ready;
    logic [2:0]  en;
    logic [8:0]  src;    // requester index feeding port p at [p*3+:3]
    logic [17:0] waddr;  // expected port address, 0 when disabled
  } vec_t;

  function automatic logic [29:0] pa(input int a0, a1, a2, a3, a4);
    return {6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [8:0] ps(input int s0, s1, s2);
    return {3'(s2), 3'(s1), 3'(s0)};
  endfunction

  function automatic logic [17:0] pw(input int w0, w1, w2);
    return {6'(w2), 6'(w1), 6'(w0)};
  endfunction

  function automatic logic [31:0] mk_data(input int v, input int i);
    return 32'hD000_0000 | (32'(v) << 8) | 32'(i);
  endfunction

  task automatic drive_data(input int v);
    for (int i = 0; i < 5; i++) in_data[i*32 +: 32] = mk_data(v, i);
  endtask

  task automatic check(input string name, input int v, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, v, act, exp);
    end
  endtask

  vec_t vecs [14];

  initial begin
    logic [95:0] exp_wd;
    logic [2:0]  s;

    // ptr evolution in comments is the expected round-robin pointer before each vector
    vecs[0]  = '{5'b11111, pa(1,2,3,4,5),     5'b00111, 3'b111, ps(0,1,2), pw(1,2,3)};    // ptr0 -> 3
    vecs[1]  = '{5'b11111, pa(1,2,3,4,5),     5'b11001, 3'b111, ps(3,4,0), pw(4,5,1)};    // ptr3 -> 1
    vecs[2]  = '{5'b11111, pa(1,2,3,4,5),     5'b01110, 3'b111, ps(1,2,3), pw(2,3,4)};    // ptr1 -> 4
    vecs[3]  = '{5'b11111, pa(1,2,3,4,5),     5'b10011, 3'b111, ps(4,0,1), pw(5,1,2)};    // ptr4 -> 2
    vecs[4]  = '{5'b00000, pa(1,2,3,4,5),     5'b00000, 3'b000, ps(0,0,0), pw(0,0,0)};    // ptr2 stays
    vecs[5]  = '{5'b01000, pa(0,0,0,20,0),    5'b01000, 3'b001, ps(3,0,0), pw(20,0,0)};   // ptr2 -> 4
    vecs[6]  = '{5'b10001, pa(6,0,0,0,0),     5'b10001, 3'b001, ps(0,0,0), pw(6,0,0)};    // ptr4 -> 1
    vecs[7]  = '{5'b10000, pa(0,0,0,0,8),     5'b10000, 3'b001, ps(4,0,0), pw(8,0,0)};    // ptr1 -> 0
    vecs[8]  = '{5'b00111, pa(7,7,9,0,0),     5'b00101, 3'b011, ps(0,2,0), pw(7,9,0)};    // ptr0 -> 3
    vecs[9]  = '{5'b00010, pa(7,7,9,0,0),     5'b00010, 3'b001, ps(1,0,0), pw(7,0,0)};    // ptr3 -> 2
    vecs[10] = '{5'b10000, pa(0,0,0,0,31),    5'b10000, 3'b001, ps(4,0,0), pw(31,0,0)};   // ptr2 -> 0
    vecs[11] = '{5'b11111, pa(0,10,11,12,13), 5'b01111, 3'b111, ps(1,2,3), pw(10,11,12)}; // ptr0 -> 4
    vecs[12] = '{5'b11111, pa(5,5,5,5,5),     5'b10000, 3'b001, ps(4,0,0), pw(5,0,0)};    // ptr4 -> 0
    vecs[13] = '{5'b11111, pa(1,2,3,4,5),     5'b00111, 3'b111, ps(0,1,2), pw(1,2,3)};    // ptr0 -> 3

    rst      = 1'b1;
    in_valid = 5'b11111;
    in_addr  = pa(1,2,3,4,5);
    in_data  = '0;
    drive_data(99);

    for (int c = 0; c < 2; c++) begin
      #1;
      check("rst_ready", c, 128'(out_ready), 128'(5'b00000));
      @(posedge clk); #1;
      check("rst_we", c, 128'(out_we), 128'(3'b000));
      check("rst_wa", c, 128'(out_wa), 128'(18'd0));
      @(negedge clk);
    end
    rst = 1'b0;

    for (int v = 0; v < 14; v++) begin
      in_valid = vecs[v].valid;
      in_addr  = vecs[v].addr;
      drive_data(v);
      #1;
      check("ready", v, 128'(out_ready), 128'(vecs[v].ready));
      @(posedge clk); #1;
      exp_wd = '0;
      for (int p = 0; p < 3; p++) begin
        s = vecs[v].src[p*3 +: 3];
        if (vecs[v].en[p]) exp_wd[p*32 +: 32] = mk_data(v, int'(s));
      end
      check("we", v, 128'(out_we), 128'(vecs[v].en));
      check("waddr", v, 128'(out_wa), 128'(vecs[v].waddr));
      check("wdata", v, 128'(out_wd), 128'(exp_wd));
      $display("vec %0d valid=%b ready=%b we=%b wa=%h", v, in_valid, out_ready, out_we, out_wa);
      @(negedge clk);
    end

    // Mid-operation reset with three grants pending (ptr=3 here): all discarded.
    in_valid = 5'b11111;
    in_addr  = pa(1,2,3,4,5);
    drive_data(50);
    rst = 1'b1;
    #1;
    check("midrst_ready", 50, 128'(out_ready), 128'(5'b00000));
    @(posedge clk); #1;
    check("midrst_we", 50, 128'(out_we), 128'(3'b000));
    check("midrst_wa", 50, 128'(out_wa), 128'(18'd0));
    check("midrst_wd", 50, 128'(out_wd), 128'(96'd0));
    $display("midrst ready=%b we=%b", out_ready, out_we);
    @(negedge clk);
    rst = 1'b0;
    drive_data(51);
    #1;
    check("postrst_ready", 51, 128'(out_ready), 128'(5'b00111));
    @(posedge clk); #1;
    check("postrst_we", 51, 128'(out_we), 128'(3'b111));
    check("postrst_wa", 51, 128'(out_wa), 128'(pw(1,2,3)));
    check("postrst_wd", 51, 128'(out_wd), 128'({mk_data(51,2), mk_data(51,1), mk_data(51,0)}));
    $display("postrst ready=%b we=%b wa=%h", out_ready, out_we, out_wa);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
